stoch_maxpool_sched: RTL and testbench

STOCH_MAXPOOL_SCHED -- requirements
Module: stoch_maxpool_sched

---
 rtl/stoch_maxpool_sched_if.sv | 26 ++
 rtl/stoch_maxpool_sched.sv | 104 ++++++++++
 tb/tb_stoch_maxpool_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/stoch_maxpool_sched_if.sv
// Bundle between the max-pool scheduler and its job source / max-unit array.
// Bitstream beats are valid-only: the scheduler never back-pressures, and a beat is consumed exactly when en=1.
interface stoch_maxpool_sched_if #(
    parameter int GW = 1
);
    logic          start;
    logic          abort;
    logic          x_valid;
    logic          clr;
    logic          en;
    logic          y_valid;
    logic          busy;
    logic          done;
    logic [GW-1:0] group_idx;
    logic [2:0]    state_dbg;

    modport master (
        output start, abort, x_valid,
        input  clr, en, y_valid, busy, done, group_idx, state_dbg
    );

    modport slave (
        input  start, abort, x_valid,
        output clr, en, y_valid, busy, done, group_idx, state_dbg
    );
endinterface

// File: rtl/stoch_maxpool_sched.sv
// Pass scheduler for stochastic max-pooling: for each channel group, clear the
// max units, run a warm-up window, then stream STREAM_LEN result bits.
module stoch_maxpool_sched #(
    parameter int CHANNELS   = 256,
    parameter int CH_GROUP   = 16,
    parameter int STREAM_LEN = 256,
    parameter int WARMUP     = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    stoch_maxpool_sched_if.slave   bus
);
    localparam int NUM_GROUPS = CHANNELS / CH_GROUP;
    localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int MAX_LEN    = (STREAM_LEN > WARMUP) ? STREAM_LEN : WARMUP;
    localparam int CW         = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] WARM_LAST   = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CW-1:0] STREAM_LAST = CW'(STREAM_LEN - 1);
    localparam logic [GW-1:0] GROUP_LAST  = GW'(NUM_GROUPS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_WARMUP = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] group_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            group_q <= '0;
        end else if (bus.abort && state != S_IDLE) begin
            // Abort wins over every other transition and drops the job silently.
            state   <= S_IDLE;
            cnt     <= '0;
            group_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state   <= S_CLEAR;
                        cnt     <= '0;
                        group_q <= '0;
                    end
                end
                S_CLEAR: begin
                    cnt   <= '0;
                    state <= (WARMUP > 0) ? S_WARMUP : S_STREAM;
                end
                S_WARMUP: begin
                    if (bus.x_valid) begin
                        if (cnt == WARM_LAST) begin
                            cnt   <= '0;
                            state <= S_STREAM;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (bus.x_valid) begin
                        if (cnt == STREAM_LAST) begin
                            cnt <= '0;
                            if (group_q == GROUP_LAST) begin
                                state <= S_DONE;
                            end else begin
                                group_q <= group_q + 1'b1;
                                state   <= S_CLEAR;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    group_q <= '0;
                end
            endcase
        end
    end

    // en/y_valid follow x_valid in the same cycle so a stalled source freezes the max units.
    always_comb begin
        bus.clr       = (state == S_CLEAR);
        bus.en        = bus.x_valid && (state == S_WARMUP || state == S_STREAM);
        bus.y_valid   = bus.x_valid && (state == S_STREAM);
        bus.busy      = (state != S_IDLE);
        bus.done      = (state == S_DONE);
        bus.group_idx = group_q;
        bus.state_dbg = state;
    end
endmodule

// File: tb/tb_stoch_maxpool_sched.sv
// Randomized and directed bench for stoch_maxpool_sched, checked against a
// token-queue model of the job schedule.
module tb_stoch_maxpool_sched;
    localparam int CHANNELS   = 4;
    localparam int CH_GROUP   = 2;
    localparam int WARMUP     = 2;
    localparam int STREAM_LEN = 4;
    localparam int NG         = CHANNELS / CH_GROUP;

    localparam int K_CLR  = 0;
    localparam int K_WRM  = 1;
    localparam int K_STR  = 2;
    localparam int K_DONE = 3;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    always #5 CLK = ~CLK;

    stoch_maxpool_sched_if #(.GW(1)) bus ();
    stoch_maxpool_sched_if #(.GW(1)) bus2 ();

    stoch_maxpool_sched #(
        .CHANNELS(CHANNELS), .CH_GROUP(CH_GROUP),
        .STREAM_LEN(STREAM_LEN), .WARMUP(WARMUP)
    ) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus.slave)
    );

    stoch_maxpool_sched #(
        .CHANNELS(2), .CH_GROUP(2), .STREAM_LEN(1), .WARMUP(0)
    ) dut2 (
        .CLK(CLK), .nRST(nRST), .bus(bus2.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: the remaining job is a queue of tokens (group*4 + kind).
    int mq[$];
    int m_grp = 0;

    int cyc, ycnt, bcnt, done_cyc, done_n, y_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_load();
        for (int g = 0; g < NG; g++) begin
            mq.push_back(g * 4 + K_CLR);
            for (int i = 0; i < WARMUP; i++) mq.push_back(g * 4 + K_WRM);
            for (int i = 0; i < STREAM_LEN; i++) mq.push_back(g * 4 + K_STR);
        end
        mq.push_back((NG - 1) * 4 + K_DONE);
    endtask

    task automatic m_reset();
        mq.delete();
        m_grp = 0;
    endtask

    task automatic check_outputs(input logic xv);
        int kind;
        int g;
        if (mq.size() == 0) begin
            check("clr", bus.clr, 0);
            check("en", bus.en, 0);
            check("y_valid", bus.y_valid, 0);
            check("busy", bus.busy, 0);
            check("done", bus.done, 0);
            check("group_idx", bus.group_idx, m_grp);
        end else begin
            kind = mq[0] % 4;
            g    = mq[0] / 4;
            check("clr", bus.clr, kind == K_CLR);
            check("en", bus.en, xv && (kind == K_WRM || kind == K_STR));
            check("y_valid", bus.y_valid, xv && kind == K_STR);
            check("busy", bus.busy, 1);
            check("done", bus.done, kind == K_DONE);
            check("group_idx", bus.group_idx, g);
        end
    endtask

    task automatic m_advance(input logic s, input logic a, input logic xv);
        int kind;
        if (mq.size() != 0 && a) begin
            m_reset();
        end else if (mq.size() == 0) begin
            if (s && !a) begin
                m_load();
                m_grp = 0;
            end
        end else begin
            kind  = mq[0] % 4;
            m_grp = mq[0] / 4;
            if (kind == K_CLR || kind == K_DONE || xv) void'(mq.pop_front());
        end
    endtask

    task automatic begin_run();
        cyc = 0; ycnt = 0; bcnt = 0; done_cyc = -1; done_n = 0; y_first = -1;
    endtask

    task automatic step(input logic s, input logic a, input logic xv);
        @(negedge CLK);
        bus.start   = s;
        bus.abort   = a;
        bus.x_valid = xv;
        #1;
        check_outputs(xv);
        if (bus.y_valid) begin
            if (ycnt == 0) y_first = cyc;
            ycnt++;
        end
        if (bus.busy) bcnt++;
        if (bus.done) begin
            done_cyc = cyc;
            done_n++;
        end
        m_advance(s, a, xv);
        cyc++;
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.x_valid = 0;
        bus2.start = 0; bus2.abort = 0; bus2.x_valid = 0;
        m_reset();

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_clr", bus.clr, 0);
        check("rst_grp", bus.group_idx, 0);
        nRST = 1'b1;

        // Degenerate config: no warm-up, one-bit stream, one group
        @(negedge CLK);
        bus2.start = 1; bus2.x_valid = 1;
        #1;
        check("d2_c0_busy", bus2.busy, 0);
        @(negedge CLK);
        bus2.start = 0;
        #1;
        check("d2_c1_clr", bus2.clr, 1);
        check("d2_c1_y", bus2.y_valid, 0);
        @(negedge CLK); #1;
        check("d2_c2_clr", bus2.clr, 0);
        check("d2_c2_y", bus2.y_valid, 1);
        check("d2_c2_done", bus2.done, 0);
        @(negedge CLK); #1;
        check("d2_c3_done", bus2.done, 1);
        check("d2_c3_y", bus2.y_valid, 0);
        @(negedge CLK); #1;
        check("d2_c4_busy", bus2.busy, 0);
        check("d2_c4_done", bus2.done, 0);
        bus2.x_valid = 0;

        // Nominal job, x_valid held high
        begin_run();
        step(1, 0, 1);
        for (int c = 1; c <= 16; c++) step(0, 0, 1);
        check("nom_done_cyc", done_cyc, 15);
        check("nom_done_n", done_n, 1);
        check("nom_ycnt", ycnt, 8);
        check("nom_busy_cycles", bcnt, 15);
        check("nom_y_first", y_first, 4);

        // Three-cycle stall in group 0 stream
        begin_run();
        step(1, 0, 1);
        for (int c = 1; c <= 20; c++) step(0, 0, !(c >= 5 && c <= 7));
        check("stall_done_cyc", done_cyc, 18);
        check("stall_ycnt", ycnt, 8);

        // Abort at cycle 9, restart at 12
        begin_run();
        step(1, 0, 1);
        for (int c = 1; c <= 30; c++) step(c == 12, c == 9, 1);
        check("abort_done_n", done_n, 1);
        check("abort_done_cyc", done_cyc, 27);

        // start held through a whole job
        begin_run();
        for (int c = 0; c <= 32; c++) step(1, 0, 1);
        check("hold_done_n", done_n, 2);
        check("hold_done_cyc", done_cyc, 31);
        for (int c = 0; c < 20; c++) step(0, 0, 1);

        // Asynchronous reset mid-job
        begin_run();
        step(1, 0, 1);
        for (int c = 1; c <= 4; c++) step(0, 0, 1);
        step(0, 0, 1);
        #2;
        nRST = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_en", bus.en, 0);
        check("arst_y", bus.y_valid, 0);
        check("arst_clr", bus.clr, 0);
        check("arst_grp", bus.group_idx, 0);
        m_reset();
        step(0, 0, 1);
        step(0, 0, 1);
        @(negedge CLK);
        nRST = 1'b1;
        begin_run();
        step(1, 0, 1);
        for (int c = 1; c <= 16; c++) step(0, 0, 1);
        check("arst_done_n", done_n, 1);
        check("arst_done_cyc", done_cyc, 15);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
